// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage registers of the 5-stage core:
// FSM state encodings and default payload widths per stage boundary.
package pipe_pkg;

    // Stage occupancy: EMPTY (no entry), FULL (main slot), SKID (main + skid slots)
    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_FULL  = 2'd1,
        PIPE_SKID  = 2'd2
    } pipe_state_e;

    // Generic defaults
    localparam int unsigned PIPE_DEF_DATA_W  = 32;
    localparam int unsigned PIPE_DEF_CTRL_W  = 2;
    localparam int unsigned PIPE_DEF_STALL_W = 16;

    // Per-boundary defaults
    localparam int unsigned IFID_DATA_W  = 64;  // {pc, instr}
    localparam int unsigned IFID_CTRL_W  = 1;
    localparam int unsigned IDEX_DATA_W  = 32;
    localparam int unsigned IDEX_CTRL_W  = 8;
    localparam int unsigned EXMEM_DATA_W = 32;
    localparam int unsigned EXMEM_CTRL_W = 4;
    localparam int unsigned MEMWB_DATA_W = 32;
    localparam int unsigned MEMWB_CTRL_W = 2;

endpackage : pipe_pkg

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush and bubble insertion. in_ready is a flop, so downstream
// backpressure never forms a combinational path to upstream.
//
// Ports:
//   clk, reset      rising-edge clock; asynchronous active-low reset
//   flush           synchronous kill of all held entries (wins over handshake)
//   in_valid/ready  upstream handshake (in_ready registered)
//   in_data/ctrl    upstream payload / control bits
//   out_valid/ready downstream handshake
//   out_data/ctrl   main-slot payload / control (ctrl is 0 whenever out_valid=0)
//   stall_cnt       saturating backpressure counter (only with PIPE_STALL_CNT_EN)
//
// Configuration: define PIPE_STALL_CNT_EN to add the STALL_W parameter, the
// stall_cnt port and its counter.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W  = PIPE_DEF_DATA_W,
    parameter int unsigned CTRL_W  = PIPE_DEF_CTRL_W
`ifdef PIPE_STALL_CNT_EN
    ,
    parameter int unsigned STALL_W = PIPE_DEF_STALL_W
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [STALL_W-1:0] stall_cnt
`endif
);

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              accept;
    logic              issue;

    assign accept = in_valid & in_ready_q;
    assign issue  = out_valid_q & out_ready;

    // Next-state, slot update, flush override and registered handshake outputs
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        unique case (state_q)
            PIPE_EMPTY: begin
                if (accept) begin
                    state_d     = PIPE_FULL;
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end
            end
            PIPE_FULL: begin
                if (accept && out_ready) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end else if (accept) begin
                    state_d     = PIPE_SKID;
                    skid_data_d = in_data;
                    skid_ctrl_d = in_ctrl;
                end else if (issue) begin
                    // Bubble: ctrl must read 0 while empty
                    state_d     = PIPE_EMPTY;
                    main_ctrl_d = '0;
                end
            end
            PIPE_SKID: begin
                if (issue) begin
                    state_d     = PIPE_FULL;
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                    skid_ctrl_d = '0;
                end
            end
            default: begin
                state_d     = PIPE_EMPTY;
                main_ctrl_d = '0;
                skid_ctrl_d = '0;
            end
        endcase

        // Flush discards any same-cycle accept/issue; data slots keep their contents
        if (flush) begin
            state_d     = PIPE_EMPTY;
            main_data_d = main_data_q;
            skid_data_d = skid_data_q;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end

        in_ready_d  = (state_d != PIPE_SKID);
        out_valid_d = (state_d != PIPE_EMPTY);
    end

    // State and slot registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= PIPE_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;

`ifdef PIPE_STALL_CNT_EN
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles an entry waits on downstream
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready && !flush && (stall_cnt_q != {STALL_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule : pipe_stage_elastic

// File: tb/tb_pipe_stage_elastic.sv
// Directed self-checking bench for pipe_stage_elastic.
`timescale 1ns/1ps
module tb_pipe_stage_elastic;
    import pipe_pkg::*;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CTRL_W  = 2;
`ifdef PIPE_STALL_CNT_EN
    localparam int unsigned STALL_W = 4;
`endif

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
`ifdef PIPE_STALL_CNT_EN
    logic [STALL_W-1:0] stall_cnt;
`endif

    int unsigned n_checks;
    int unsigned n_errors;

`ifdef PIPE_STALL_CNT_EN
    pipe_stage_elastic #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .STALL_W(STALL_W)) dut (
`else
    pipe_stage_elastic #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
`endif
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, '0, '0);

        // 1. Reset
        repeat (3) step();
        reset = 1'b1;
        step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_ctrl",  64'(out_ctrl),  64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_data",  64'(out_data),  64'd0);

        // 2. Streaming with out_ready=1
        out_ready = 1'b1;
        drive(1'b1, 32'h1, 2'b01);
        step();
        check("s1_data", 64'(out_data), 64'h1);
        check("s1_ctrl", 64'(out_ctrl), 64'h1);
        check("s1_rdy",  64'(in_ready), 64'd1);
        drive(1'b1, 32'h2, 2'b01);
        step();
        check("s2_data", 64'(out_data), 64'h2);
        check("s2_rdy",  64'(in_ready), 64'd1);
        drive(1'b1, 32'h3, 2'b01);
        step();
        check("s3_data",  64'(out_data),  64'h3);
        check("s3_valid", 64'(out_valid), 64'd1);
        drive(1'b0, '0, '0);
        step();
        check("s_drain_valid", 64'(out_valid), 64'd0);
        check("s_drain_ctrl",  64'(out_ctrl),  64'd0);

        // 3. Backpressure into skid and drain in order
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 2'b10);
        step();
        check("bp_a_data", 64'(out_data), 64'hA);
        check("bp_a_rdy",  64'(in_ready), 64'd1);
        drive(1'b1, 32'hB, 2'b01);
        step();
        check("bp_skid_data", 64'(out_data), 64'hA);
        check("bp_skid_ctrl", 64'(out_ctrl), 64'h2);
        check("bp_skid_rdy",  64'(in_ready), 64'd0);
        drive(1'b1, 32'hC, 2'b11);  // must not be accepted while in_ready=0
        step();
        check("bp_hold_data", 64'(out_data), 64'hA);
        check("bp_hold_rdy",  64'(in_ready), 64'd0);
        drive(1'b0, '0, '0);
        out_ready = 1'b1;
        step();
        check("bp_b_data", 64'(out_data), 64'hB);
        check("bp_b_ctrl", 64'(out_ctrl), 64'h1);
        check("bp_b_rdy",  64'(in_ready), 64'd1);
        step();
        check("bp_empty_valid", 64'(out_valid), 64'd0);
        check("bp_empty_data",  64'(out_data),  64'hB);

        // 4. Flush while in SKID
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 2'b11);
        step();
        drive(1'b1, 32'hB, 2'b11);
        step();
        check("fl_pre_ctrl", 64'(out_ctrl), 64'h3);
        check("fl_pre_rdy",  64'(in_ready), 64'd0);
        drive(1'b0, '0, '0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ctrl",  64'(out_ctrl),  64'd0);
        check("fl_rdy",   64'(in_ready),  64'd1);
        check("fl_data_hold", 64'(out_data), 64'hA);
        out_ready = 1'b1;
        repeat (3) begin
            step();
            check("fl_no_b", 64'(out_valid), 64'd0);
        end

        // 5. Flush together with an accept
        drive(1'b1, 32'h55, 2'b11);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        check("fa_valid", 64'(out_valid), 64'd0);
        check("fa_data",  64'(out_data),  64'hA);
        step();
        check("fa_valid2", 64'(out_valid), 64'd0);
        check("fa_ctrl2",  64'(out_ctrl),  64'd0);

`ifdef PIPE_STALL_CNT_EN
        // 6. Stall counter saturation and reset clear
        out_ready = 1'b0;
        drive(1'b1, 32'h77, 2'b01);
        step();
        drive(1'b0, '0, '0);
        check("sc_start", 64'(stall_cnt), 64'd0);
        repeat (3) step();
        check("sc_three", 64'(stall_cnt), 64'd3);
        repeat (17) step();
        check("sc_sat", 64'(stall_cnt), 64'd15);
        check("sc_data_stable", 64'(out_data), 64'h77);
        reset = 1'b0;
        #1;
        check("sc_rst", 64'(stall_cnt), 64'd0);
        step();
        reset = 1'b1;
        step();
`endif

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        drive(1'b1, 32'h99, 2'b11);
        step();
        check("mr_pre_valid", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mr_valid", 64'(out_valid), 64'd0);
        check("mr_ctrl",  64'(out_ctrl),  64'd0);
        check("mr_data",  64'(out_data),  64'd0);
        check("mr_rdy",   64'(in_ready),  64'd1);
        drive(1'b0, '0, '0);
        step();
        reset = 1'b1;
        step();
        check("mr_post_valid", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_pipe_stage_elastic
